// File: rtl/pattern_pkg.sv
// Shared types for the binary frame streamer: FSM states, per-pixel sideband
// flags and the constant used to expand a 1-bit BRAM pixel to a full-width word.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } stream_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    // A lit pixel drives every output bit high; sliced down to the pixel width.
    localparam int unsigned PIX_MAX_W = 64;
    localparam logic [PIX_MAX_W-1:0] PIX_ONES = {PIX_MAX_W{1'b1}};

endpackage

// File: rtl/stream_skid_fifo.sv
// Purpose: 2-entry synchronous FIFO carrying pixel + sideband words.
// Latency: a pushed word is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: rd_vld is purely registered; a push into a full FIFO is dropped unless a pop frees a slot.
module stream_skid_fifo #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    always_comb begin
        rd_vld   = (count_q != 2'd0);
        pop      = rd_vld && rd_rdy;
        push     = wr_vld && ((count_q != 2'd2) || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Flush wins over a same-cycle push so an in-flight word is discarded.
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/binary_frame_streamer.sv
// Purpose: streams a 1-bit frame from BRAM as W-bit pixels with sof/eol/eof sideband.
// Latency: start sampled at edge t -> read_en in cycle t+1 -> first y_valid in cycle t+3.
// Backpressure: reads are issued only while FIFO words plus the pending read fit in 2 slots; y_valid never depends on y_ready.
module binary_frame_streamer
    import pattern_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_to_read,
    input  logic                  start,
    input  logic                  abort,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [W-1:0]          y_data,
    output logic                  y_sof,
    output logic                  y_eol,
    output logic                  y_eof,
    output logic                  busy,
    output logic                  done
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int FW   = W + 3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [CW-1:0]         LAST_COL  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(IMG_HEIGHT - 1);

    stream_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  pend_q, pend_d;
    pix_flags_t            pend_flags_q, pend_flags_d;
    logic                  done_q, done_d;

    pix_flags_t            cur_flags;
    pix_flags_t            head_flags;
    logic                  issue;
    logic                  pop;
    logic [2:0]            committed;
    logic                  fifo_vld;
    logic [FW-1:0]         fifo_dat;
    logic [FW-1:0]         fifo_wr_dat;
    logic [1:0]            fifo_count;

    assign head_flags = pix_flags_t'(fifo_dat[FW-1:W]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        col_d        = col_q;
        row_d        = row_q;
        done_d       = 1'b0;
        issue        = 1'b0;
        pop          = fifo_vld && y_ready;

        cur_flags.sof = (col_q == '0) && (row_q == '0);
        cur_flags.eol = (col_q == LAST_COL);
        cur_flags.eof = (col_q == LAST_COL) && (row_q == LAST_ROW);

        // Slots already claimed once this cycle's pop has left the FIFO.
        committed = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};

        case (state_q)
            IDLE: begin
                if (start && valid_to_read) begin
                    state_d = STREAM;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            STREAM: begin
                issue = (committed < 3'd2);
                if (issue) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head_flags.eof) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            issue   = 1'b0;
            done_d  = 1'b0;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
        end

        pend_d       = issue;
        pend_flags_d = cur_flags;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pend_q       <= 1'b0;
            pend_flags_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pend_q       <= pend_d;
            pend_flags_q <= pend_flags_d;
            done_q       <= done_d;
        end
    end

    assign fifo_wr_dat = {pend_flags_q, (read_data ? PIX_ONES[W-1:0] : {W{1'b0}})};

    stream_skid_fifo #(
        .DW (FW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (abort),
        .wr_vld (pend_q),
        .wr_dat (fifo_wr_dat),
        .rd_vld (fifo_vld),
        .rd_rdy (y_ready),
        .rd_dat (fifo_dat),
        .count  (fifo_count)
    );

    assign read_en   = issue;
    assign read_addr = addr_q;
    assign y_valid   = fifo_vld;
    assign y_data    = fifo_vld ? fifo_dat[W-1:0] : '0;
    assign y_sof     = fifo_vld && head_flags.sof;
    assign y_eol     = fifo_vld && head_flags.eol;
    assign y_eof     = fifo_vld && head_flags.eof;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_binary_frame_streamer.sv
// Directed bench for binary_frame_streamer on a 4x3 frame whose pixels alternate 1,0,1,0...
module tb_binary_frame_streamer;

    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int PW   = 8;
    localparam int AW   = 4;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          rst, valid_to_read, start, abort;
    logic          read_en, read_data;
    logic [AW-1:0] read_addr;
    logic          y_valid, y_ready, y_sof, y_eol, y_eof, busy, done;
    logic [PW-1:0] y_data;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic img [NPIX];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) read_data <= read_en ? img[read_addr] : 1'b0;

    binary_frame_streamer #(
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .W          (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_to_read (valid_to_read),
        .start         (start),
        .abort         (abort),
        .read_en       (read_en),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .y_data        (y_data),
        .y_sof         (y_sof),
        .y_eol         (y_eol),
        .y_eof         (y_eof),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_pix(input int k);
        return (k % 2 == 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic chk_pix(input string tag, input int k);
        chk({tag, "_data"}, 32'(y_data), 32'(exp_pix(k)));
        chk({tag, "_sof"},  32'(y_sof),  32'(k == 0));
        chk({tag, "_eol"},  32'(y_eol),  32'(k % IW == IW - 1));
        chk({tag, "_eof"},  32'(y_eof),  32'(k == NPIX - 1));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_read_en"}, 32'(read_en),   32'(0));
        chk({tag, "_addr"},    32'(read_addr), 32'(0));
        chk({tag, "_y_valid"}, 32'(y_valid),   32'(0));
        chk({tag, "_y_data"},  32'(y_data),    32'(0));
        chk({tag, "_flags"},   32'({y_sof, y_eol, y_eof}), 32'(0));
        chk({tag, "_busy"},    32'(busy),      32'(0));
        chk({tag, "_done"},    32'(done),      32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int             acc;
        int             iss;
        int             dones;
        int             events;
        logic           prev_stall;
        logic [PW+2:0]  prev_word;

        rst = 1'b1; start = 1'b0; abort = 1'b0; valid_to_read = 1'b0; y_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) img[i] = (i % 2 == 0);
        tick();
        tick();
        rst = 1'b0;
        mid();
        chk_reset_outs("reset");
        tick();

        // Full frame, y_ready held high, start presented in cycle 10.
        while (cyc < 10) tick();
        valid_to_read = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 11; c <= 26; c++) begin
            mid();
            chk("t1_read_en", 32'(read_en), 32'(c >= 11 && c <= 22));
            if (c >= 11 && c <= 22) chk("t1_addr", 32'(read_addr), 32'(c - 11));
            chk("t1_y_valid", 32'(y_valid), 32'(c >= 13 && c <= 24));
            if (c >= 13 && c <= 24) chk_pix("t1_pix", c - 13);
            chk("t1_done", 32'(done), 32'(c == 25));
            chk("t1_busy", 32'(busy), 32'(c >= 11 && c <= 24));
            tick();
            if (c == 15) valid_to_read = 1'b0;
        end
        valid_to_read = 1'b1;

        // Same frame with y_ready cycling 1,0,0,1.
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0; iss = 0; dones = 0; prev_stall = 1'b0; prev_word = '0;
        for (int n = 0; n < 80 && dones == 0; n++) begin
            y_ready = (n % 4 == 0) || (n % 4 == 3);
            mid();
            if (prev_stall) begin
                chk("t2_hold_valid", 32'(y_valid), 32'(1));
                chk("t2_hold_word", 32'({y_data, y_sof, y_eol, y_eof}), 32'(prev_word));
            end
            if (read_en) begin
                chk("t2_addr", 32'(read_addr), 32'(iss));
                iss++;
            end
            if (y_valid && y_ready) begin
                chk_pix("t2_pix", acc);
                acc++;
            end
            chk("t2_ahead", 32'(iss - acc <= 2), 32'(1));
            if (done) dones++;
            prev_stall = y_valid && !y_ready;
            prev_word  = {y_data, y_sof, y_eol, y_eof};
            tick();
        end
        chk("t2_count", 32'(acc), 32'(NPIX));
        chk("t2_dones", 32'(dones), 32'(1));
        y_ready = 1'b1;

        // start without a captured frame is ignored.
        valid_to_read = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        events = 0;
        for (int n = 0; n < 20; n++) begin
            mid();
            if (read_en || busy) events++;
            tick();
        end
        chk("t3_no_activity", 32'(events), 32'(0));
        valid_to_read = 1'b1;

        // abort beats start; rst beats start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        mid();
        chk("abort_start_busy", 32'(busy), 32'(0));
        chk("abort_start_read_en", 32'(read_en), 32'(0));
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        mid();
        chk("rst_start_busy", 32'(busy), 32'(0));
        tick();

        // Abort while pixel 5 is presented and stalled, then restart.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 8; n++) tick();
        abort = 1'b1; y_ready = 1'b0;
        mid();
        chk("t4_pix5_valid", 32'(y_valid), 32'(1));
        chk_pix("t4_pix5", 5);
        tick();
        abort = 1'b0;
        mid();
        chk("t4_post_valid", 32'(y_valid), 32'(0));
        chk("t4_post_busy", 32'(busy), 32'(0));
        chk("t4_post_read_en", 32'(read_en), 32'(0));
        tick();
        y_ready = 1'b1;
        events = 0;
        for (int n = 0; n < 10; n++) begin
            mid();
            if (done || y_valid) events++;
            tick();
        end
        chk("t4_quiet", 32'(events), 32'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0; dones = 0;
        for (int n = 1; n < 40 && dones == 0; n++) begin
            mid();
            if (n == 1) begin
                chk("t4_restart_read_en", 32'(read_en), 32'(1));
                chk("t4_restart_addr", 32'(read_addr), 32'(0));
            end
            if (n == 3) chk("t4_restart_valid", 32'(y_valid), 32'(1));
            if (y_valid && y_ready) begin
                chk_pix("t4_pix", acc);
                acc++;
            end
            if (done) dones++;
            tick();
        end
        chk("t4_count", 32'(acc), 32'(NPIX));
        chk("t4_dones", 32'(dones), 32'(1));

        // start re-pulsed while pixel 6 is presented.
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0; dones = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 9) start = 1'b1;
            mid();
            if (y_valid && y_ready) begin
                chk_pix("t5_pix", acc);
                acc++;
            end
            if (done) dones++;
            tick();
            start = 1'b0;
        end
        chk("t5_count", 32'(acc), 32'(NPIX));
        chk("t5_dones", 32'(dones), 32'(1));

        // rst while pixel 7 is presented.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 10; n++) tick();
        rst = 1'b1;
        mid();
        chk("t6_pix7_valid", 32'(y_valid), 32'(1));
        chk_pix("t6_pix7", 7);
        tick();
        rst = 1'b0;
        mid();
        chk_reset_outs("t6_after_rst");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
